// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Each digit owns a fixed slot: a short all-dark blanking gap, then the digit
// is driven. Display updates wait in a one-entry pending buffer and are
// committed only at frame boundaries, so a frame never mixes old and new data.
module seven_seg_scan_ctrl #(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_data,
    input  logic [3:0]  upd_mask,
    output logic [3:0]  digit_code,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(TICKS_PER_DIGIT);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    // Scan state
    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic             en_q;

    // Active (displayed) and pending (buffered) update
    logic [15:0] act_data;
    logic [3:0]  act_mask;
    logic [15:0] pend_data;
    logic [3:0]  pend_mask;
    logic        pend_full;

    // Next-state values
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       idx_d;
    logic             commit;
    logic             load_code;
    logic             frame_d;
    logic             accept;
    logic [15:0]      data_nxt;
    logic [3:0]       mask_nxt;
    logic [3:0]       code_d;
    logic [3:0]       an_d;

    assign upd_ready = ~pend_full;
    assign accept    = upd_valid & ~pend_full;

    // Slot sequencing: blank gap, driven phase, advance to next digit; en low
    // parks the scan at the start of slot 0, and its first high edge restarts
    // a frame there.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        commit    = 1'b0;
        load_code = 1'b0;
        frame_d   = 1'b0;
        if (!en || !en_q) begin
            // Parked, or restarting: hold slot 0 blank and flush any pending
            // update so digit 0 shows the latest data.
            state_d   = ST_BLANK;
            cnt_d     = '0;
            idx_d     = 2'd0;
            commit    = pend_full;
            load_code = 1'b1;
            frame_d   = en;
        end else if (state_q == ST_BLANK) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == BLANK_LAST) begin
                state_d = ST_ON;
            end
        end else if (cnt_q == CNT_LAST) begin
            // End of slot: next digit, blank first. Leaving digit 3 is the
            // frame boundary, the only place a running scan commits.
            state_d   = ST_BLANK;
            cnt_d     = '0;
            idx_d     = idx_q + 2'd1;
            load_code = 1'b1;
            if (idx_q == 2'd3) begin
                commit  = pend_full;
                frame_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Output decode of the next state, so an and digit_code register cleanly
    always_comb begin
        data_nxt = commit ? pend_data : act_data;
        mask_nxt = commit ? pend_mask : act_mask;
        code_d   = load_code ? data_nxt[{idx_d, 2'b00} +: 4] : digit_code;
        an_d     = 4'b1111;
        if (state_d == ST_ON && mask_nxt[idx_d]) begin
            an_d = ~(4'b0001 << idx_d);
        end
    end

    // Scan registers and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            en_q        <= 1'b0;
            an          <= 4'b1111;
            digit_code  <= 4'hF;
            frame_start <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            en_q        <= en;
            an          <= an_d;
            digit_code  <= code_d;
            frame_start <= frame_d;
        end
    end

    // Update buffer: accept into pending when empty, move to active on commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data buffers are reset too; they are a handful of
            // flops, and reset must throw away any queued update.
            act_data  <= 16'hFFFF;
            act_mask  <= 4'b0000;
            pend_data <= 16'hFFFF;
            pend_mask <= 4'b0000;
            pend_full <= 1'b0;
        end else begin
            act_data <= data_nxt;
            act_mask <= mask_nxt;
            if (accept) begin
                pend_data <= upd_data;
                pend_mask <= upd_mask;
                pend_full <= 1'b1;
            end else if (commit) begin
                pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with 8-tick slots, 2 blank ticks.
// A frame-time model (cycle position inside a 32-cycle frame) predicts every
// output each cycle; directed literal checks pin the model to hand values.
module tb_seven_seg_scan_ctrl;

    localparam int TPD   = 8;
    localparam int BT    = 2;
    localparam int FRAME = 4 * TPD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] upd_data = 16'h0000;
    logic [3:0]  upd_mask = 4'h0;
    logic [3:0]  digit_code;
    logic [3:0]  an;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    seven_seg_scan_ctrl #(
        .TICKS_PER_DIGIT (TPD),
        .BLANK_TICKS     (BT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_data    (upd_data),
        .upd_mask    (upd_mask),
        .digit_code  (digit_code),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t is the cycle position within the current frame (0..31) while running.
    bit          m_running;
    int          m_t;
    logic [15:0] m_data;
    logic [3:0]  m_mask;
    logic [15:0] m_pdata;
    logic [3:0]  m_pmask;
    bit          m_pfull;
    bit          m_frame;

    logic m_start, m_wrap, m_commit, m_accept;
    assign m_start  = en && !m_running;
    assign m_wrap   = en && m_running && (m_t == FRAME - 1);
    assign m_commit = m_pfull && (!en || m_start || m_wrap);
    assign m_accept = upd_valid && !m_pfull;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running <= 1'b0;
            m_t       <= 0;
            m_data    <= 16'hFFFF;
            m_mask    <= 4'b0000;
            m_pdata   <= 16'hFFFF;
            m_pmask   <= 4'b0000;
            m_pfull   <= 1'b0;
            m_frame   <= 1'b0;
        end else begin
            m_running <= en;
            m_t       <= (!en || m_start || m_wrap) ? 0 : m_t + 1;
            m_frame   <= m_start || m_wrap;
            if (m_commit) begin
                m_data <= m_pdata;
                m_mask <= m_pmask;
            end
            if (m_accept) begin
                m_pdata <= upd_data;
                m_pmask <= upd_mask;
                m_pfull <= 1'b1;
            end else if (m_commit) begin
                m_pfull <= 1'b0;
            end
        end
    end

    int         exp_slot;
    logic [3:0] exp_code;
    logic [3:0] exp_an;
    always_comb begin
        exp_slot = m_running ? m_t / TPD : 0;
        exp_code = m_data[exp_slot*4 +: 4];
        exp_an   = 4'b1111;
        if (m_running && (m_t % TPD) >= BT && m_mask[exp_slot])
            exp_an = ~(4'b0001 << exp_slot);
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_an",          32'(an),          32'(exp_an));
            check("cyc_digit_code",  32'(digit_code),  32'(exp_code));
            check("cyc_frame_start", 32'(frame_start), 32'(m_frame));
            check("cyc_upd_ready",   32'(upd_ready),   32'(!m_pfull));
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_frame(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_start && cycles < 100);
        check("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] m, output int waited);
        upd_valid = 1'b1;
        upd_data  = d;
        upd_mask  = m;
        waited    = 0;
        while (!upd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("accept_seen", 32'(upd_ready), 32'd1);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int         cyc, waited, nfs, last_fs, lows, bad;
        logic [3:0] seen [4];
        int         on_cnt [4];
        logic [3:0] pat [4];
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

        repeat (2) @(negedge clk);
        check("reset_an",    32'(an),          32'hF);
        check("reset_code",  32'(digit_code),  32'hF);
        check("reset_ready", 32'(upd_ready),   32'd1);
        check("reset_fs",    32'(frame_start), 32'd0);
        cmp_on = 1'b1;
        rst_n  = 1'b1;
        en     = 1'b1;

        // 1: idle scan, nothing lit, frame pulses every 32 cycles
        wait_frame(cyc);
        check("t1_first_frame_latency", 32'(cyc), 32'd1);
        nfs = 0; last_fs = 0; lows = 0; bad = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) begin nfs++; last_fs = i; end
            if (an != 4'hF) lows++;
            if (digit_code != 4'hF) bad++;
        end
        check("t1_frame_count", 32'(nfs), 32'd2);
        check("t1_frame_period", 32'(last_fs), 32'd64);
        check("t1_no_anode_low", 32'(lows), 32'd0);
        check("t1_code_blank", 32'(bad), 32'd0);

        // 2: full-mask update, shown from the next frame
        send(16'h0A21, 4'b1111, waited);
        check("t2_accept_wait", 32'(waited), 32'd0);
        wait_frame(cyc);
        check("t2_frame_wait", 32'(cyc), 32'd31);
        check("t2_slot0_code_at_start", 32'(digit_code), 32'h1);
        check("t2_slot0_blank_at_start", 32'(an), 32'hF);
        bad = 0;
        for (int s = 0; s < 4; s++) on_cnt[s] = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i % TPD == 0) seen[i / TPD] = digit_code;
            if (digit_code != seen[i / TPD]) bad++;
            if (an == pat[i / TPD]) on_cnt[i / TPD]++;
            @(negedge clk);
        end
        check("t2_code_slot0", 32'(seen[0]), 32'h1);
        check("t2_code_slot1", 32'(seen[1]), 32'h2);
        check("t2_code_slot2", 32'(seen[2]), 32'hA);
        check("t2_code_slot3", 32'(seen[3]), 32'h0);
        check("t2_code_stable", 32'(bad), 32'd0);
        for (int s = 0; s < 4; s++) check($sformatf("t2_on_cycles_slot%0d", s), 32'(on_cnt[s]), 32'd6);

        // 3: mask 0101, digits 1 and 3 stay dark
        send(16'h0A21, 4'b0101, waited);
        wait_frame(cyc);
        bad = 0; on_cnt[0] = 0; on_cnt[2] = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (!an[1] || !an[3]) bad++;
            if (an == 4'b1110) on_cnt[0]++;
            if (an == 4'b1011) on_cnt[2]++;
            @(negedge clk);
        end
        check("t3_masked_dark", 32'(bad), 32'd0);
        check("t3_slot0_on", 32'(on_cnt[0]), 32'd6);
        check("t3_slot2_on", 32'(on_cnt[2]), 32'd6);

        // 4: back-to-back updates, second waits for the frame boundary
        send(16'h1234, 4'b1111, waited);
        check("t4_first_accept_wait", 32'(waited), 32'd0);
        send(16'h5678, 4'b1111, waited);
        check("t4_second_accept_wait", 32'(waited), 32'd31);
        check("t4_first_shown", 32'(digit_code), 32'h4);
        wait_frame(cyc);
        check("t4_first_one_frame", 32'(cyc), 32'd31);
        check("t4_second_shown", 32'(digit_code), 32'h8);

        // 5: drop en mid-ON of slot 2, then re-enable
        repeat (20) @(negedge clk);
        check("t5_slot2_on", 32'(an), 32'b1011);
        en = 1'b0;
        @(negedge clk);
        check("t5_dark_after_disable", 32'(an), 32'hF);
        check("t5_code_digit0", 32'(digit_code), 32'h8);
        check("t5_no_frame_disabled", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("t5_restart_frame", 32'(frame_start), 32'd1);
        check("t5_restart_blank0", 32'(an), 32'hF);
        @(negedge clk);
        check("t5_frame_one_cycle", 32'(frame_start), 32'd0);
        check("t5_restart_blank1", 32'(an), 32'hF);
        @(negedge clk);
        check("t5_slot0_on", 32'(an), 32'b1110);

        // 6: async reset with pending full while slot 2 is driven
        send(16'h9999, 4'b1111, waited);
        repeat (16) @(negedge clk);
        check("t6_slot2_on", 32'(an), 32'b1011);
        check("t6_pending_full", 32'(upd_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_an", 32'(an), 32'hF);
        check("t6_async_ready", 32'(upd_ready), 32'd1);
        check("t6_async_code", 32'(digit_code), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame(cyc);
        lows = 0; bad = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk);
            if (an != 4'hF) lows++;
            if (digit_code != 4'hF) bad++;
        end
        check("t6_discarded_dark", 32'(lows), 32'd0);
        check("t6_discarded_code", 32'(bad), 32'd0);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
